// File: rtl/sram_arb_pkg.sv
// Shared definitions for the multi-port SRAM arbiter and its round-robin picker.
// Holds the FSM state encoding and the port-index width helper.
// Optional feature macro SRAM_WAITSTATE_EN adds the ST_WAIT state to the FSM.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Width of a port index; at least one bit so a 1-port build still has a legal vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping modulo NPORTS.
// Zero latency; pure combinational.
// No backpressure of its own; any_req tells the caller whether gnt is valid.
module rr_arbiter #(
  parameter int NPORTS = 2,
  parameter int IW     = 1
) (
  input  logic [NPORTS-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [IW-1:0]     gnt,
  output logic              any_req
);

  // Scan from the farthest offset down to the pointer so the closest requester wins last.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    gnt     = '0;
    any_req = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NPORTS)) begin
        sum = sum - (IW+1)'(NPORTS);
      end
      idx = sum[IW-1:0];
      if (req[idx]) begin
        gnt     = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter_mp.sv
// Shares one async SRAM among NPORTS req/ack clients with idle-skipping round-robin.
// Access = SETUP, STROBE, DONE (3 cycles req-to-ack); SRAM_WAITSTATE_EN adds WAIT (4 cycles).
// A client holds req until its ack pulse; other clients simply wait for their grant.
module sram_arbiter_mp
  import sram_arb_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int AW     = 19,
  parameter int DW     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NPORTS-1:0]    req,
  input  logic [NPORTS-1:0]    we,
  input  logic [NPORTS*AW-1:0] addr,
  input  logic [NPORTS*DW-1:0] din,
  output logic [NPORTS-1:0]    ack,
  output logic [NPORTS*DW-1:0] dout,
  output logic [AW-1:0]        sram_a,
  inout  wire  [DW-1:0]        sram_d,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n
);

  localparam int IW = idx_w(NPORTS);

  state_t            state;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     win;
  logic              l_we;
  logic              drv_en;
  logic [DW-1:0]     drv_dat;

  logic [NPORTS-1:0] win_mask;
  logic [NPORTS-1:0] arb_req;
  logic [IW-1:0]     arb_ptr;
  logic [IW-1:0]     next_ptr;
  logic [IW-1:0]     gnt;
  logic              any_req;

  // The data bus is only driven while a write is in SETUP/STROBE(/WAIT).
  assign sram_d = drv_en ? drv_dat : {DW{1'bz}};

  assign next_ptr = (win == IW'(NPORTS - 1)) ? '0 : win + 1'b1;

  // In DONE the finishing client has not yet seen its ack, so its still-high req is ignored.
  always_comb begin
    win_mask = '0;
    for (int i = 0; i < NPORTS; i++) begin
      win_mask[i] = (state == ST_DONE) && (win == IW'(i));
    end
  end

  assign arb_req = req & ~win_mask;
  assign arb_ptr = (state == ST_DONE) ? next_ptr : ptr;

  rr_arbiter #(
    .NPORTS (NPORTS),
    .IW     (IW)
  ) u_rr (
    .req     (arb_req),
    .ptr     (arb_ptr),
    .gnt     (gnt),
    .any_req (any_req)
  );

  // Access sequencer; all SRAM pins and acks are registered to give clean strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      win       <= '0;
      l_we      <= 1'b0;
      ack       <= '0;
      dout      <= '0;
      sram_a    <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      drv_en    <= 1'b0;
      drv_dat   <= '0;
    end else begin
      ack <= '0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (state == ST_DONE) begin
            ptr <= next_ptr;
          end
          if (any_req) begin
            win       <= gnt;
            l_we      <= we[gnt];
            sram_a    <= addr[int'(gnt)*AW +: AW];
            drv_dat   <= din[int'(gnt)*DW +: DW];
            drv_en    <= we[gnt];
            sram_ce_n <= 1'b0;
            sram_oe_n <= we[gnt];
            sram_we_n <= 1'b1;
            state     <= ST_SETUP;
          end else begin
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            drv_en    <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        ST_SETUP: begin
          sram_we_n <= ~l_we;
          state     <= ST_STROBE;
        end

`ifdef SRAM_WAITSTATE_EN
        ST_STROBE: begin
          state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (!l_we) begin
            dout[int'(win)*DW +: DW] <= sram_d;
          end
          ack[win]  <= 1'b1;
          sram_ce_n <= 1'b1;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          drv_en    <= 1'b0;
          state     <= ST_DONE;
        end
`else
        ST_STROBE: begin
          if (!l_we) begin
            dout[int'(win)*DW +: DW] <= sram_d;
          end
          ack[win]  <= 1'b1;
          sram_ce_n <= 1'b1;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          drv_en    <= 1'b0;
          state     <= ST_DONE;
        end
`endif

        default: begin
          sram_ce_n <= 1'b1;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          drv_en    <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter_mp.sv
// Bench for sram_arbiter_mp with four client ports, an async SRAM model and a reference model.
// Directed cases pin latency, strobe widths, grant order and reset abort; random traffic follows.
// Checks run every cycle at the falling edge against the transaction-level model.
module tb_sram_arbiter_mp;

  localparam int NP = 4;
  localparam int AW = 19;
  localparam int DW = 8;
`ifdef SRAM_WAITSTATE_EN
  localparam int L = 4;
`else
  localparam int L = 3;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NP-1:0]     req;
  logic [NP-1:0]     we;
  logic [NP*AW-1:0]  addr;
  logic [NP*DW-1:0]  din;
  wire  [NP-1:0]     ack;
  wire  [NP*DW-1:0]  dout;
  wire  [AW-1:0]     sram_a;
  wire  [DW-1:0]     sram_d;
  wire               sram_ce_n;
  wire               sram_oe_n;
  wire               sram_we_n;

  sram_arbiter_mp #(
    .NPORTS (NP),
    .AW     (AW),
    .DW     (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .din       (din),
    .ack       (ack),
    .dout      (dout),
    .sram_a    (sram_a),
    .sram_d    (sram_d),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n)
  );

  // Board SRAM: drives the bus while selected for read, captures data while we_n is low.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          pre_vld;
  logic [AW-1:0] pre_a;
  logic [DW-1:0] pre_d;

  assign sram_d = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_a] : {DW{1'bz}};

  always @(posedge clk) begin
    if (pre_vld) mem[pre_a] <= pre_d;
    else if (!sram_ce_n && !sram_we_n) mem[sram_a] <= sram_d;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit             busy = 1'b0;
  int             ph = 0;
  int             mwin = 0;
  int             ptr_m = 0;
  int             p0;
  int             ii;
  logic [NP-1:0]  cand;
  logic           mwe = 1'b0;
  logic [AW-1:0]  ma = '0;
  logic [DW-1:0]  md = '0;
  logic [NP*DW-1:0] dout_m = '0;
  logic [DW-1:0]  mem_m [int];
  logic [NP-1:0]  e_ack = '0;
  logic           e_ce = 1'b1, e_oe = 1'b1, e_we = 1'b1, e_drv = 1'b0;
  bit             chk_en = 1'b0;

  initial forever begin
    @(posedge clk);
    if (pre_vld) mem_m[int'(pre_a)] = pre_d;
    if (rst) begin
      busy   = 1'b0;
      ptr_m  = 0;
      dout_m = '0;
    end else begin
      if (!busy || ph == L) begin
        cand = req;
        p0   = ptr_m;
        if (busy) begin
          cand[mwin] = 1'b0;
          ptr_m      = (mwin + 1) % NP;
          p0         = ptr_m;
        end
        busy = 1'b0;
        for (int k = 0; k < NP; k++) begin
          ii = (p0 + k) % NP;
          if (!busy && cand[ii]) begin
            busy = 1'b1;
            mwin = ii;
            mwe  = we[ii];
            ma   = addr[ii*AW +: AW];
            md   = din[ii*DW +: DW];
            ph   = 1;
          end
        end
      end else begin
        if (ph == L - 1) begin
          if (mwe) mem_m[int'(ma)] = md;
          else     dout_m[mwin*DW +: DW] = mem_m[int'(ma)];
        end
        ph++;
      end
    end
    e_ack = '0;
    if (busy && ph == L) e_ack[mwin] = 1'b1;
    e_ce  = !(busy && ph < L);
    e_oe  = !(busy && ph < L && !mwe);
    e_we  = !(busy && mwe && ph >= 2 && ph < L);
    e_drv = busy && mwe && ph < L;
  end

  // Per-cycle comparison of every DUT output against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("ack", ack, e_ack);
      check("ce_n", sram_ce_n, e_ce);
      check("oe_n", sram_oe_n, e_oe);
      check("we_n", sram_we_n, e_we);
      check("dout", dout, dout_m);
      if (!e_ce) check("sram_a", sram_a, ma);
      if (e_drv) check("sram_d", sram_d, md);
    end
  end

  // ---------------- stimulus helpers ----------------
  int order [0:199];
  int tack  [0:199];

  task automatic set_req(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[p]           = 1'b1;
    we[p]            = w;
    addr[p*AW +: AW] = a;
    din[p*DW +: DW]  = d;
  endtask

  task automatic set_rand(input int p);
    set_req(p, 1'($urandom % 2), AW'($urandom_range(0, 15)), DW'($urandom));
  endtask

  task automatic access(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int lat, output int oe_lo, output int we_lo);
    bit got = 1'b0;
    lat = 0; oe_lo = 0; we_lo = 0;
    set_req(p, w, a, d);
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (!sram_oe_n) oe_lo++;
      if (!sram_we_n) we_lo++;
      if (w && !sram_ce_n) check("wr_bus_lit", sram_d, d);
      if (ack[p]) begin
        got = 1'b1;
        lat = c;
      end
    end
    req[p] = 1'b0;
    check("ack_seen", got, 1);
  endtask

  task automatic serve(input int nrec, input bit rnd, input int bound);
    int cnt = 0;
    int cyc = 0;
    while ((cnt < nrec || req != '0) && cyc < bound) begin
      @(negedge clk);
      cyc++;
      for (int p = 0; p < NP; p++) begin
        if (req[p] && ack[p]) begin
          if (cnt < 200) begin
            order[cnt] = p;
            tack[cnt]  = cyc;
          end
          cnt++;
          if (cnt >= nrec || (rnd && $urandom % 3 == 0)) req[p] = 1'b0;
          else set_rand(p);
        end else if (rnd && !req[p] && cnt < nrec && $urandom % 4 == 0) begin
          set_rand(p);
        end
      end
    end
    check("serve_in_time", (cyc < bound), 1);
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int lat, oe_lo, we_lo;
  bit seen_we;

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; din = '0;
    pre_vld = 1'b0; pre_a = '0; pre_d = '0;

    // Preload the SRAM while in reset.
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      pre_vld = 1'b1;
      pre_a   = (i == 16) ? AW'('h00123) : AW'(i);
      pre_d   = (i == 16) ? 8'hA5 : DW'($urandom);
    end
    @(negedge clk);
    pre_vld = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    check("rst_ack", ack, 0);
    check("rst_dout", dout, 0);
    check("rst_sram_a", sram_a, 0);
    check("rst_ce_n", sram_ce_n, 1);
    check("rst_oe_n", sram_oe_n, 1);
    check("rst_we_n", sram_we_n, 1);
    rst = 1'b0;
    @(negedge clk);

    // Single read from port 0.
    access(0, 1'b0, AW'('h00123), 8'h00, lat, oe_lo, we_lo);
    check("rd_latency", lat, L);
    check("rd_oe_low_cycles", oe_lo, L - 1);
    check("rd_we_low_cycles", we_lo, 0);
    check("rd_dout0", dout[0*DW +: DW], 8'hA5);

    // Single write from port 1 to the top address, then read it back.
    access(1, 1'b1, AW'('h7FFFF), 8'h3C, lat, oe_lo, we_lo);
    check("wr_latency", lat, L);
    check("wr_we_low_cycles", we_lo, L - 2);
    check("wr_oe_low_cycles", oe_lo, 0);
    access(1, 1'b0, AW'('h7FFFF), 8'h00, lat, oe_lo, we_lo);
    check("wr_readback", dout[1*DW +: DW], 8'h3C);

    // Round robin with all ports held continuously.
    rst_pulse();
    for (int p = 0; p < NP; p++) set_req(p, 1'b0, AW'($urandom_range(0, 15)), 8'h00);
    serve(8, 1'b0, 200);
    for (int i = 0; i < 8; i++) check("rr_order", order[i], i % NP);
    for (int i = 1; i < 8; i++) check("rr_spacing", tack[i] - tack[i-1], L);

    // Skip idle ports: pointer left at 2 after a port-1 access.
    rst_pulse();
    access(1, 1'b0, AW'(3), 8'h00, lat, oe_lo, we_lo);
    set_req(1, 1'b0, AW'(4), 8'h00);
    set_req(3, 1'b0, AW'(5), 8'h00);
    serve(3, 1'b0, 100);
    check("skip_g0", order[0], 3);
    check("skip_g1", order[1], 1);
    check("skip_g2", order[2], 3);

    // Reset during the strobe of a write.
    set_req(2, 1'b1, AW'('h55555), 8'h5A);
    seen_we = 1'b0;
    for (int c = 0; c < 10 && !seen_we; c++) begin
      @(negedge clk);
      if (!sram_we_n) seen_we = 1'b1;
    end
    check("abort_strobe_seen", seen_we, 1);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check("abort_ack", ack, 0);
    check("abort_ce_n", sram_ce_n, 1);
    check("abort_we_n", sram_we_n, 1);
    check("abort_oe_n", sram_oe_n, 1);
    rst = 1'b0;
    access(2, 1'b0, AW'('h00123), 8'h00, lat, oe_lo, we_lo);
    check("post_abort_latency", lat, L);
    check("post_abort_dout2", dout[2*DW +: DW], 8'hA5);

    // Randomized traffic checked cycle by cycle against the model.
    serve(150, 1'b1, 4000);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
